// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE-array sequencer.
//   state_t : sequencer states
//   tag_t   : per-cycle result tag {valid, row, och} that travels beside the array pipeline
//   ROW_W / OCH_W : default counter widths
package pe_ctrl_pkg;

  localparam int ROW_W = 6;
  localparam int OCH_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    WAIT_W = 3'd2,
    FEED   = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [OCH_W-1:0] och;
  } tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register that carries result tags alongside the free-running
// PE array, so a tag pushed in cycle t appears on dout in cycle t+DEPTH.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high; clears only the valid bit (MSB) of every stage
//   din  : tag pushed this cycle, valid bit in the MSB
//   dout : tag pushed DEPTH cycles ago
module tag_delay_line #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Payload bits carry no reset; a cleared valid bit is enough to kill the entry.
  always_ff @(posedge clk) begin
    stage[0] <= din;
    for (int i = 1; i < DEPTH; i++) begin
      stage[i] <= stage[i-1];
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i][WIDTH-1] <= 1'b0;
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Sequencer for the 72-PE 3x3 convolution array. For each output channel it
// reads the filter/bias word, streams ifmap row-triples into the array, then
// drains the shared-filter pipeline before moving to the next channel. Every
// array output cycle is tagged with valid/row/channel for the psum buffer.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; all strobes low
// LOAD_W | filter/bias SRAM read for channel och
// WAIT_W | SRAM latency; filter holding register latched on last cycle
// FEED   | one ifmap row-triple read per cycle, rows 0..cfg_rows-1
// DRAIN  | MEM_LAT+PIPE_LAT idle cycles so the last row leaves the array
// DONE   | one-cycle done pulse
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, cfg_rows, cfg_och : job request and size, sampled in IDLE only
//   busy, done               : job status
//   wgt_rd_en, wgt_rd_addr   : filter/bias SRAM read (addr driven only while reading)
//   wgt_latch                : capture strobe for the filter holding register
//   ifmap_rd_en, ifmap_row   : ifmap SRAM read of rows r..r+2 (row driven only while reading)
//   psum_valid/row/och       : tag for the result currently leaving the array
module pe_array_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 4,
  parameter int MEM_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [OCH_W-1:0] cfg_och,
  output logic             busy,
  output logic             done,
  output logic             wgt_rd_en,
  output logic [OCH_W-1:0] wgt_rd_addr,
  output logic             wgt_latch,
  output logic             ifmap_rd_en,
  output logic [ROW_W-1:0] ifmap_row,
  output logic             psum_valid,
  output logic [ROW_W-1:0] psum_row,
  output logic [OCH_W-1:0] psum_och
);

  localparam int L     = MEM_LAT + PIPE_LAT;
  localparam int TMR_W = $clog2(L + 1);

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row, rows_cfg, rows_last;
  logic [OCH_W-1:0] och, och_cfg, och_last;
  logic [TMR_W-1:0] tmr;
  logic             cfg_ok;
  tag_t             tag_in, tag_out;

  assign cfg_ok    = (cfg_rows != '0) && (cfg_och != '0);
  assign rows_last = rows_cfg - ROW_W'(1);
  assign och_last  = och_cfg - OCH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wgt_rd_en   = 1'b0;
    wgt_latch   = 1'b0;
    ifmap_rd_en = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = cfg_ok ? LOAD_W : DONE;
        end
      end
      LOAD_W: begin
        wgt_rd_en = 1'b1;
        state_nxt = WAIT_W;
      end
      WAIT_W: begin
        if (tmr == '0) begin
          wgt_latch = 1'b1;
          state_nxt = FEED;
        end
      end
      FEED: begin
        ifmap_rd_en = 1'b1;
        if (row == rows_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (tmr == '0) begin
          state_nxt = (och == och_last) ? DONE : LOAD_W;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters and the shared down-counter tmr (SRAM wait, then pipeline drain).
  // Both stop at their last value, so no wrap is possible at max config.
  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      och      <= '0;
      tmr      <= '0;
      rows_cfg <= '0;
      och_cfg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            rows_cfg <= cfg_rows;
            och_cfg  <= cfg_och;
            och      <= '0;
          end
        end
        LOAD_W: tmr <= TMR_W'(MEM_LAT - 1);
        WAIT_W: begin
          row <= '0;
          if (tmr != '0) tmr <= tmr - TMR_W'(1);
        end
        FEED: begin
          if (row != rows_last) row <= row + ROW_W'(1);
          else                  tmr <= TMR_W'(L - 1);
        end
        DRAIN: begin
          if (tmr != '0)            tmr <= tmr - TMR_W'(1);
          else if (och != och_last) och <= och + OCH_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign wgt_rd_addr = wgt_rd_en ? och : '0;
  assign ifmap_row   = ifmap_rd_en ? row : '0;

  assign tag_in.valid = ifmap_rd_en;
  assign tag_in.row   = row;
  assign tag_in.och   = och;

  tag_delay_line #(
    .DEPTH (L),
    .WIDTH ($bits(tag_t))
  ) u_tags (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  // Payload of an invalid stage is stale; force the tags to zero instead.
  assign psum_valid = tag_out.valid;
  assign psum_row   = tag_out.valid ? tag_out.row : '0;
  assign psum_och   = tag_out.valid ? tag_out.och : '0;

endmodule

// File: doc/pe_array_seq_ctrl.md
Name: pe_array_seq_ctrl

Overview:
Sequencer for the 72-PE 3x3 convolution array.
- Per output channel: fetches the 72-bit filter/16-bit bias word, streams ifmap row-triples into the array, then drains the pipeline before switching filters.
- Tags each array output cycle with valid/row/channel so the downstream psum buffer knows which result is arriving.
- Sits between the weight/ifmap SRAMs and the PE array; the array itself has no enables and is free-running.

Parameters:
PIPE_LAT, 4, cycles from ifmap/filter present at array input to toPsum valid
MEM_LAT, 1, SRAM read latency (rd_en cycle to data on bus)
ROW_W, 6, row counter width
OCH_W, 4, output-channel counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  job request; sampled only in IDLE
cfg_rows  in  ROW_W  output rows per channel; captured on accepted start
cfg_och  in  OCH_W  output channels per job; captured on accepted start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job end
wgt_rd_en  out  1  filter/bias SRAM read strobe
wgt_rd_addr  out  OCH_W  current channel index
wgt_latch  out  1  capture strobe for the filter/bias holding register feeding the array
ifmap_rd_en  out  1  ifmap SRAM read strobe; SRAM returns rows r, r+1, r+2 on ifmapIn1..3
ifmap_row  out  ROW_W  top row index r
psum_valid  out  1  toPsum carries a valid result this cycle
psum_row  out  ROW_W  row tag for toPsum
psum_och  out  OCH_W  channel tag for toPsum

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0; all delay-line valid bits cleared.
- Reset mid-job: abort immediately. In-flight results are discarded (no psum_valid). No done pulse.
- Let L = MEM_LAT + PIPE_LAT.
- IDLE:
  - start=1 with cfg_rows != 0 and cfg_och != 0: capture config; och=0; go to LOAD_W.
  - start=1 with either config field 0: go straight to DONE (zero-size job).
  - start=0: stay in IDLE.
- LOAD_W, 1 cycle: wgt_rd_en=1, wgt_rd_addr=och. Next state WAIT_W.
- WAIT_W, 1 cycle: wgt_latch=1, valid only for MEM_LAT=1. Row=0. Next state FEED.
  - For MEM_LAT>1, WAIT_W lasts MEM_LAT cycles; wgt_latch is high on the last of them.
- FEED, cfg_rows cycles: ifmap_rd_en=1, ifmap_row=row, row++.
  - After the cycle with row=cfg_rows-1, go to DRAIN.
- DRAIN, exactly L cycles, no reads. Required because the filter is shared by every pipeline stage.
  - Then if och+1 < cfg_och: och++, go to LOAD_W.
  - Else: go to DONE.
- DONE, 1 cycle: done=1. Next state IDLE.
- start is ignored outside IDLE, including in DONE.
- Tag timing: each FEED cycle t pushes {1, row, och} into an L-deep delay line. psum_valid/psum_row/psum_och equal that entry at cycle t+L. The last psum_valid therefore coincides with the last DRAIN cycle, and done follows in the next cycle.
- Non-FEED cycles push valid=0.
- Counters never wrap: row tops out at cfg_rows-1 and och at cfg_och-1. With max config (63 rows, 15 och) no overflow occurs.
- Config changes while busy have no effect.

Decomposition:
- Package pe_ctrl_pkg holds:
  - the state enum (IDLE, LOAD_W, WAIT_W, FEED, DRAIN, DONE);
  - ROW_W/OCH_W defaults;
  - the tag struct {valid, row, och}.
- Sub-module tag_delay_line: parameterised depth L and width; sync-reset clears valid bits only.
- The FSM and counters stay in the top module.

Test Plan:
- Single channel, cfg_rows=2, cfg_och=1, start at cycle 0 -> LOAD_W@1, WAIT_W@2, ifmap_rd_en@3,4 (row 0,1), psum_valid@8,9 (row 0,1, och 0), done@10, busy 1..10.
- cfg_rows=3, cfg_och=2 -> second wgt_rd_en with addr=1 only after 5 DRAIN cycles; psum_och=1 on rows 0..2; exactly 6 psum_valid pulses; single done.
- cfg_rows=0 (or cfg_och=0) -> done one cycle after start; no rd_en, no psum_valid.
- rst asserted during DRAIN of channel 0 -> next cycle all outputs 0, IDLE; no psum_valid afterwards; new start runs a full job normally.
- start held high continuously through a job with cfg_rows=1, cfg_och=1 -> second job begins only from IDLE after done; start during busy and DONE has no effect.
- Max config 63 rows / 15 channels -> 945 psum_valid pulses; last tag row=62, och=14; no counter wrap.
